// File: rtl/qcl_thermo_pkg.sv
// Shared types and helpers for the thermometer-code blocks.
// thermo_count_width(w) is the width needed to hold a count in 0..w.
package qcl_thermo_pkg;

    typedef enum logic {
        THERMO_HI_TO_LO = 1'b0,
        THERMO_LO_TO_HI = 1'b1
    } thermo_dir_e;

    function automatic int thermo_count_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/qcl_thermo_run_len.sv
// Combinational thermometer-mask encoder: anchored run length plus a flag
// for masks that are not a legal thermometer code.
module qcl_thermo_run_len
    import qcl_thermo_pkg::*;
#(
    parameter int width_p    = 8,
    parameter bit lo_to_hi_p = 1'b1
) (
    input  logic [width_p-1:0]                        mask,
    output logic [thermo_count_width(width_p)-1:0]    count,
    output logic                                      err
);

    localparam int          count_width_lp = thermo_count_width(width_p);
    localparam thermo_dir_e dir_lp         = lo_to_hi_p ? THERMO_LO_TO_HI : THERMO_HI_TO_LO;

    logic [width_p-1:0] norm;
    logic               seen_zero;
    int                 run;

    // Normalise so the run always starts at bit 0, then scan upward; any 1
    // after the first 0 makes the mask illegal.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        norm      = '0;
        run       = 0;
        seen_zero = 1'b0;
        err       = 1'b0;
        for (int i = 0; i < width_p; i++) begin
            norm[i] = (dir_lp == THERMO_LO_TO_HI) ? mask[i] : mask[width_p-1-i];
        end
        // NOTE: blocking assignments here, because later loop iterations
        // read values written by earlier ones in the same evaluation.
        for (int i = 0; i < width_p; i++) begin
            if (!norm[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                err = 1'b1;
            end else begin
                run = run + 1;
            end
        end
    end

    assign count = count_width_lp'(run);

endmodule

// File: rtl/qcl_encode_thermo_pipe.sv
// Two-stage valid/ready pipeline turning thermometer masks back into counts.
// Define QCL_ENCODE_THERMO_ERRCNT_EN to build the saturating illegal-mask counter.
module qcl_encode_thermo_pipe
    import qcl_thermo_pkg::*;
#(
    parameter int width_p         = 8,
    parameter bit lo_to_hi_p      = 1'b1,
    parameter int err_cnt_width_p = 8
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      v_i,
    input  logic [width_p-1:0]                        mask_i,
    output logic                                      ready_o,
    output logic                                      v_o,
    output logic [thermo_count_width(width_p)-1:0]    count_o,
    output logic                                      err_o,
    input  logic                                      ready_i,
    input  logic                                      clear_i,
    output logic [err_cnt_width_p-1:0]                err_count_o
);

    localparam int count_width_lp = thermo_count_width(width_p);

    if (width_p < 1) begin : g_width_check
        $fatal(1, "qcl_encode_thermo_pipe: width_p must be >= 1");
    end

    logic                      s1_v;
    logic [width_p-1:0]        s1_mask;
    logic                      s2_v;
    logic [count_width_lp-1:0] s2_count;
    logic                      s2_err;
    logic [count_width_lp-1:0] rl_count;
    logic                      rl_err;
    logic                      s1_adv;
    logic                      s2_adv;

    assign s2_adv  = !s2_v || ready_i;
    assign s1_adv  = !s1_v || s2_adv;
    assign ready_o = s1_adv;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= v_i;
        end
    end

    // NOTE: s1_mask is data only and always qualified by s1_v, so it is
    // deliberately left without a reset.
    always_ff @(posedge clk_i) begin
        if (s1_adv && v_i) begin
            s1_mask <= mask_i;
        end
    end

    qcl_thermo_run_len #(
        .width_p    (width_p),
        .lo_to_hi_p (lo_to_hi_p)
    ) u_run_len (
        .mask  (s1_mask),
        .count (rl_count),
        .err   (rl_err)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_v     <= 1'b0;
            s2_count <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_count <= rl_count;
                s2_err   <= rl_err;
            end
        end
    end

    assign v_o     = s2_v;
    assign count_o = s2_count;
    assign err_o   = s2_err;

`ifdef QCL_ENCODE_THERMO_ERRCNT_EN
    logic [err_cnt_width_p-1:0] err_count;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_count <= '0;
        end else if (clear_i) begin
            err_count <= '0;
        end else if (s2_v && ready_i && s2_err && (err_count != '1)) begin
            err_count <= err_count + err_cnt_width_p'(1);
        end
    end

    assign err_count_o = err_count;
`else
    logic unused_clear;

    assign unused_clear = clear_i;
    assign err_count_o  = '0;
`endif

endmodule

// File: tb/tb_qcl_encode_thermo_pipe.sv
// Bench for qcl_encode_thermo_pipe: three instances (8-bit lo->hi, 8-bit hi->lo,
// 1-bit) share stimulus; a queue model is checked every cycle plus directed literals.
module tb_qcl_encode_thermo_pipe;

`ifdef QCL_ENCODE_THERMO_ERRCNT_EN
    localparam bit ec_en = 1'b1;
`else
    localparam bit ec_en = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       v_i     = 1'b0;
    logic [7:0] mask    = '0;
    logic       ready_i = 1'b1;
    logic       clear_i = 1'b0;

    logic       ready_a, v_a, err_a;
    logic [3:0] cnt_a;
    logic [1:0] ec_a;
    logic       ready_b, v_b, err_b;
    logic [3:0] cnt_b;
    logic [7:0] ec_b;
    logic       ready_c, v_c, err_c;
    logic [0:0] cnt_c;
    logic [2:0] ec_c;

    always #5 clk = ~clk;

    qcl_encode_thermo_pipe #(.width_p(8), .lo_to_hi_p(1'b1), .err_cnt_width_p(2)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .mask_i(mask), .ready_o(ready_a),
        .v_o(v_a), .count_o(cnt_a), .err_o(err_a), .ready_i(ready_i), .clear_i(clear_i),
        .err_count_o(ec_a));

    qcl_encode_thermo_pipe #(.width_p(8), .lo_to_hi_p(1'b0), .err_cnt_width_p(8)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .mask_i(mask), .ready_o(ready_b),
        .v_o(v_b), .count_o(cnt_b), .err_o(err_b), .ready_i(ready_i), .clear_i(clear_i),
        .err_count_o(ec_b));

    qcl_encode_thermo_pipe #(.width_p(1), .lo_to_hi_p(1'b1), .err_cnt_width_p(3)) dut_c (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .mask_i(mask[0:0]), .ready_o(ready_c),
        .v_o(v_c), .count_o(cnt_c), .err_o(err_c), .ready_i(ready_i), .clear_i(clear_i),
        .err_count_o(ec_c));

    typedef struct {
        int cnt;
        bit err;
        int vis;
    } exp_t;

    exp_t q[3][$];
    int   ec_m[3];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   log_idx = 0;
    int   got_cnt[$];
    bit   got_err[$];
    int   got_cyc[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level model: reverse for hi->lo, count leading ones, legal iff the
    // mask equals the thermometer code of that count.
    function automatic void model(input logic [7:0] m, input int w, input bit lohi,
                                  output int cnt, output bit err);
        logic [7:0] n;
        logic [8:0] full;
        n = '0;
        for (int i = 0; i < w; i++) n[i] = lohi ? m[i] : m[w-1-i];
        cnt = 0;
        while (cnt < w && n[cnt]) cnt++;
        full = (9'd1 << cnt) - 9'd1;
        err  = ({1'b0, n} != full);
    endfunction

    task automatic mon(input int i, input int w, input bit lohi, input int ecw,
                       input logic v, input int cnt, input logic err, input logic rdy,
                       input int ec);
        string p;
        exp_t  e;
        bit    ev;
        p  = $sformatf("dut%0d.", i);
        ev = (q[i].size() > 0) && (q[i][0].vis <= cyc);
        check({p, "v_o"}, v, ev);
        if (ev) begin
            check({p, "count_o"}, cnt, q[i][0].cnt);
            check({p, "err_o"}, err, q[i][0].err);
        end
        check({p, "ready_o"}, rdy, (q[i].size() < 2) || ready_i);
        check({p, "err_count_o"}, ec, ec_en ? ec_m[i] : 0);
        if (clear_i) ec_m[i] = 0;
        else if (ev && ready_i && q[i][0].err && ec_m[i] < (1 << ecw) - 1) ec_m[i]++;
        if (ev && ready_i) begin
            if (i == log_idx) begin
                got_cnt.push_back(cnt);
                got_err.push_back(err);
                got_cyc.push_back(cyc);
            end
            void'(q[i].pop_front());
        end
        if (v_i && rdy) begin
            model(mask, w, lohi, e.cnt, e.err);
            e.vis = cyc + 2;
            q[i].push_back(e);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            ec_m[i] = 0;
        end
    endtask

    always @(negedge reset_n) flush();

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            flush();
        end else begin
            mon(0, 8, 1'b1, 2, v_a, int'(cnt_a), err_a, ready_a, int'(ec_a));
            mon(1, 8, 1'b0, 8, v_b, int'(cnt_b), err_b, ready_b, int'(ec_b));
            mon(2, 1, 1'b1, 3, v_c, int'(cnt_c), err_c, ready_c, int'(ec_c));
        end
    end

    task automatic send(input logic [7:0] m);
        bit ok;
        ok   = 1'b0;
        v_i  = 1'b1;
        mask = m;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = ready_a;
        end
        check("send_accepted", ok, 1);
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int idx);
        log_idx = idx;
        got_cnt.delete();
        got_err.delete();
        got_cyc.delete();
    endtask

    task automatic check_log(input string name, input int n, input int c[4], input bit e[4]);
        check({name, ".n_results"}, got_cnt.size(), n);
        for (int k = 0; k < n && k < got_cnt.size(); k++) begin
            check($sformatf("%s.count[%0d]", name, k), got_cnt[k], c[k]);
            check($sformatf("%s.err[%0d]", name, k), got_err[k], e[k]);
        end
    endtask

    int exp_c[4];
    bit exp_e[4];
    int exp_ec[5];

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.v_a", v_a, 0);
        check("rst.count_a", cnt_a, 0);
        check("rst.err_a", err_a, 0);
        check("rst.ec_a", ec_a, 0);
        check("rst.v_b", v_b, 0);
        check("rst.v_c", v_c, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst.ready_a", ready_a, 1);
        @(posedge clk);
        #1;

        // Scenario 1: lo->hi, full throughput.
        clear_log(0);
        send(8'h00); send(8'h0F); send(8'hFF); send(8'h0B);
        idle(6);
        exp_c = '{0, 4, 8, 2};
        exp_e = '{0, 0, 0, 1};
        check_log("s1", 4, exp_c, exp_e);
        for (int k = 1; k < got_cyc.size(); k++)
            check($sformatf("s1.spacing[%0d]", k), got_cyc[k] - got_cyc[k-1], 1);

        // Scenario 2: hi->lo anchored instance.
        clear_log(1);
        send(8'hF0); send(8'h80); send(8'hD0);
        idle(6);
        exp_c = '{4, 1, 2, 0};
        exp_e = '{0, 0, 1, 0};
        check_log("s2", 3, exp_c, exp_e);

        // Scenario 3: backpressure.
        clear_log(0);
        ready_i = 1'b0;
        send(8'h01); send(8'h03);
        v_i  = 1'b1;
        mask = 8'h07;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s3.ready_a_stalled", ready_a, 0);
            check("s3.v_a_held", v_a, 1);
            check("s3.count_a_held", cnt_a, 1);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        send(8'h07);
        idle(6);
        exp_c = '{1, 2, 3, 0};
        exp_e = '{0, 0, 0, 0};
        check_log("s3", 3, exp_c, exp_e);

        // Scenario 4/5: error counter (2-bit on dut_a), saturation and clear.
        clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("s4.ec_a_cleared", ec_a, 0);
        @(posedge clk);
        #1;
        exp_ec = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            send(8'h02);
            repeat (3) @(negedge clk);
            check($sformatf("s4.ec_a[%0d]", k), ec_a, ec_en ? exp_ec[k] : 0);
            @(posedge clk);
            #1;
        end
        send(8'h02);
        @(negedge clk);
        @(posedge clk);
        #1 clear_i = 1'b1;
        @(negedge clk);
        check("s4.err_a_pulse", err_a, 1);
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("s4.ec_a_clear_priority", ec_a, 0);
        @(posedge clk);
        #1;

        // Scenario 6: asynchronous reset with two entries in flight.
        ready_i = 1'b0;
        send(8'h01); send(8'h03);
        #2 reset_n = 1'b0;
        #1;
        check("s6.v_a_async", v_a, 0);
        check("s6.count_a_async", cnt_a, 0);
        check("s6.v_b_async", v_b, 0);
        #3 reset_n = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        check("s6.ready_a_after", ready_a, 1);
        check("s6.v_a_after", v_a, 0);
        @(posedge clk);
        #1;
        clear_log(0);
        send(8'h3F);
        idle(5);
        exp_c = '{6, 0, 0, 0};
        exp_e = '{0, 0, 0, 0};
        check_log("s6", 1, exp_c, exp_e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
